display_leitor: RTL

Receiving end of the multiplexed seven-segment display interface: samples an active-low segment bus plus active-low digit-select lines, and recovers one 6-bit code per digit position. It waits for each (segments, select) pair to be stable, decodes the pattern back to its hex/minus code, and publishes a complete frame of digits with a one-cycle valid pulse. It sits between board-level display pins, or a display-driver model in a testbench, and the checking or readback logic.

---
 rtl/display_pkg.sv | 32 +++
 rtl/seg_decod.sv | 37 +++
 rtl/display_leitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared seven-segment constants for the display driver and the readback block.
// Patterns are active-low: bit0 = segment a ... bit6 = segment g.
`timescale 1ns/1ps
package display_pkg;
    localparam logic [6:0] SEG_ZERO    = 7'h40;
    localparam logic [6:0] SEG_UM      = 7'h79;
    localparam logic [6:0] SEG_DOIS    = 7'h24;
    localparam logic [6:0] SEG_TRES    = 7'h30;
    localparam logic [6:0] SEG_QUATRO  = 7'h19;
    localparam logic [6:0] SEG_CINCO   = 7'h12;
    localparam logic [6:0] SEG_SEIS    = 7'h02;
    localparam logic [6:0] SEG_SETE    = 7'h78;
    localparam logic [6:0] SEG_OITO    = 7'h00;
    localparam logic [6:0] SEG_NOVE    = 7'h18;
    localparam logic [6:0] SEG_A       = 7'h08;
    localparam logic [6:0] SEG_B       = 7'h03;
    localparam logic [6:0] SEG_C       = 7'h46;
    localparam logic [6:0] SEG_D       = 7'h21;
    localparam logic [6:0] SEG_E       = 7'h06;
    localparam logic [6:0] SEG_F       = 7'h0E;
    localparam logic [6:0] SEG_MENOS   = 7'h3F;
    localparam logic [6:0] SEG_APAGADO = 7'h7F;

    localparam logic [5:0] COD_MENOS = 6'b111111;
    localparam logic [5:0] COD_ERRO  = 6'b111110;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CONTA     = 2'd1,
        CAPTURADO = 2'd2
    } estado_t;
endpackage

// File: rtl/seg_decod.sv
// Inverse segment table: active-low pattern back to its hex/minus code.
`timescale 1ns/1ps
module seg_decod
    import display_pkg::*;
(
    input  logic [6:0] padrao_i,
    output logic [5:0] cod_o,
    output logic       invalido_o
);
    always_comb begin
        cod_o      = COD_ERRO;
        invalido_o = 1'b0;
        case (padrao_i)
            SEG_ZERO:   cod_o = 6'd0;
            SEG_UM:     cod_o = 6'd1;
            SEG_DOIS:   cod_o = 6'd2;
            SEG_TRES:   cod_o = 6'd3;
            SEG_QUATRO: cod_o = 6'd4;
            SEG_CINCO:  cod_o = 6'd5;
            SEG_SEIS:   cod_o = 6'd6;
            SEG_SETE:   cod_o = 6'd7;
            SEG_OITO:   cod_o = 6'd8;
            SEG_NOVE:   cod_o = 6'd9;
            SEG_A:      cod_o = 6'd10;
            SEG_B:      cod_o = 6'd11;
            SEG_C:      cod_o = 6'd12;
            SEG_D:      cod_o = 6'd13;
            SEG_E:      cod_o = 6'd14;
            SEG_F:      cod_o = 6'd15;
            SEG_MENOS:  cod_o = COD_MENOS;
            default: begin
                cod_o      = COD_ERRO;
                invalido_o = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/display_leitor.sv
// Multiplexed seven-segment receiver: synchronizes pins, waits for a stable
// (segments, select) pair, decodes it into a per-digit slot and publishes frames.
`timescale 1ns/1ps
module display_leitor
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [6:0]              Hex,
    input  logic [NUM_DIGITS-1:0]   Anodo,
    output logic [6*NUM_DIGITS-1:0] Valor,
    output logic                    Valido,
    output logic                    Erro
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    // N identical samples means N-1 identical comparisons; capture on the last one.
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

    logic [6:0]            hs1_q, hs_q, hp_q;
    logic [NUM_DIGITS-1:0] as1_q, as_q, ap_q;
    estado_t               estado_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_DIGITS-1:0][5:0] slots_q;
    logic [NUM_DIGITS-1:0] seen_q;
    logic                  err_q;

    logic [5:0]    cod;
    logic          invalido;
    logic          mesmo;
    logic [3:0]    n_low;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt_inc;

    seg_decod u_decod (
        .padrao_i   (hs_q),
        .cod_o      (cod),
        .invalido_o (invalido)
    );

    assign mesmo   = (hs_q == hp_q) && (as_q == ap_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        n_low = '0;
        idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!as_q[i]) begin
                n_low = n_low + 4'd1;
                idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hs1_q    <= SEG_APAGADO;
            hs_q     <= SEG_APAGADO;
            hp_q     <= SEG_APAGADO;
            as1_q    <= '1;
            as_q     <= '1;
            ap_q     <= '1;
            estado_q <= IDLE;
            cnt_q    <= '0;
            slots_q  <= {NUM_DIGITS{COD_MENOS}};
            seen_q   <= '0;
            err_q    <= 1'b0;
            Valor    <= {NUM_DIGITS{COD_MENOS}};
            Valido   <= 1'b0;
            Erro     <= 1'b0;
        end else begin
            hs1_q  <= Hex;
            hs_q   <= hs1_q;
            hp_q   <= hs_q;
            as1_q  <= Anodo;
            as_q   <= as1_q;
            ap_q   <= as_q;
            Valido <= 1'b0;
            err_q  <= 1'b0;
            Erro   <= err_q;

            // Frame completion comes first so a same-edge capture re-sets its bit.
            if (&seen_q) begin
                Valor  <= slots_q;
                Valido <= 1'b1;
                seen_q <= '0;
            end

            case (estado_q)
                IDLE: begin
                    cnt_q    <= '0;
                    estado_q <= CONTA;
                end
                CONTA: begin
                    if (!mesmo) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_CAP) begin
                        cnt_q    <= cnt_inc;
                        estado_q <= CAPTURADO;
                        if (n_low == 4'd1) begin
                            slots_q[idx] <= cod;
                            seen_q[idx]  <= 1'b1;
                            err_q        <= invalido;
                        end else if (n_low > 4'd1) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                CAPTURADO: begin
                    if (!mesmo) begin
                        cnt_q    <= '0;
                        estado_q <= CONTA;
                    end
                end
                default: begin
                    cnt_q    <= '0;
                    estado_q <= IDLE;
                end
            endcase
        end
    end
endmodule
